// File: rtl/secuenciador_alu_pkg.sv
// Shared definitions for the ALU front-end sequencer: FSM state codes and the
// opcode table that the ALU mux decodes.
package paquete_secuenciador;

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        CALCULAR = 3'd3,
        MOSTRAR  = 3'd4
    } estado_t;

    localparam logic [3:0] OP_SUMA  = 4'd0;
    localparam logic [3:0] OP_RESTA = 4'd1;
    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MOD   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;

    localparam logic [3:0] OP_MAXIMA = 4'd9;

    // Opcodes are dense from zero, so a single upper bound decides validity.
    function automatic logic opcodeValido(input logic [3:0] codigo);
        return (codigo <= OP_MAXIMA);
    endfunction

endpackage

// File: rtl/secuenciador_alu_if.sv
// Bundle of switch, ALU and display-side signals around the sequencer.
// The master side is the surrounding board logic; the slave side is the sequencer.
interface secuenciador_alu_if #(
    parameter int ancho = 3
);

    logic [ancho:0] entradaDatos;
    logic [3:0]     entradaSeleccion;
    logic           cargar;
    logic           cancelar;
    logic           aceptado;
    logic [ancho:0] resultadoALU;
    logic [3:0]     banderasALU;

    logic [ancho:0] operandoA;
    logic [ancho:0] operandoB;
    logic [3:0]     seleccion;
    logic [ancho:0] resultado;
    logic [3:0]     banderas;
    logic           valido;
    logic           error;
    logic [2:0]     estado;
    logic [7:0]     contadorOperaciones;

    modport master (
        output entradaDatos, entradaSeleccion, cargar, cancelar, aceptado,
               resultadoALU, banderasALU,
        input  operandoA, operandoB, seleccion, resultado, banderas,
               valido, error, estado, contadorOperaciones
    );

    modport slave (
        input  entradaDatos, entradaSeleccion, cargar, cancelar, aceptado,
               resultadoALU, banderasALU,
        output operandoA, operandoB, seleccion, resultado, banderas,
               valido, error, estado, contadorOperaciones
    );

endinterface

// File: rtl/secuenciador_alu_detector.sv
// Synchronous rising-edge detector for an already debounced button level.
// The previous-level reset value decides whether a level held through reset counts as an edge.
module detector_flanco #(
    parameter logic VALOR_REINICIO = 1'b1
) (
    input  logic reloj,
    input  logic reinicio,
    input  logic nivel,
    output logic pulso
);

    logic nivelPrevio;

    always_ff @(posedge reloj) begin
        if (reinicio) begin
            nivelPrevio <= VALOR_REINICIO;
        end else begin
            nivelPrevio <= nivel;
        end
    end

    assign pulso = nivel & ~nivelPrevio;

endmodule

// File: rtl/secuenciador_alu.sv
// Front-end sequencer for the ALU: captures A, B and the opcode on successive button
// presses, lets the ALU settle one cycle, then holds the result under valid/accept.
module secuenciador_alu
    import paquete_secuenciador::*;
#(
    parameter int ancho = 3
) (
    input logic               reloj,
    input logic               reinicio,
    secuenciador_alu_if.slave bus
);

    estado_t        estadoActual;
    logic [ancho:0] regA;
    logic [ancho:0] regB;
    logic [3:0]     regSeleccion;
    logic [ancho:0] regResultado;
    logic [3:0]     regBanderas;
    logic           regValido;
    logic           regError;
    logic [7:0]     regContador;
    logic           pulso;

    // Previous level resets high so a button held through reset needs a fresh press.
    detector_flanco #(
        .VALOR_REINICIO (1'b1)
    ) detectorCargar (
        .reloj    (reloj),
        .reinicio (reinicio),
        .nivel    (bus.cargar),
        .pulso    (pulso)
    );

    // Cancel dominates every state; data registers only ever change on their own capture.
    always_ff @(posedge reloj) begin
        if (reinicio) begin
            estadoActual <= CARGA_A;
            regA         <= '0;
            regB         <= '0;
            regSeleccion <= '0;
            regResultado <= '0;
            regBanderas  <= '0;
            regValido    <= 1'b0;
            regError     <= 1'b0;
            regContador  <= '0;
        end else begin
            regError <= 1'b0;
            if (bus.cancelar) begin
                estadoActual <= CARGA_A;
                regValido    <= 1'b0;
            end else begin
                case (estadoActual)
                    CARGA_A: begin
                        if (pulso) begin
                            regA         <= bus.entradaDatos;
                            estadoActual <= CARGA_B;
                        end
                    end
                    CARGA_B: begin
                        if (pulso) begin
                            regB         <= bus.entradaDatos;
                            estadoActual <= CARGA_OP;
                        end
                    end
                    CARGA_OP: begin
                        if (pulso) begin
                            if (opcodeValido(bus.entradaSeleccion)) begin
                                regSeleccion <= bus.entradaSeleccion;
                                estadoActual <= CALCULAR;
                            end else begin
                                regError <= 1'b1;
                            end
                        end
                    end
                    // The ALU has had a full cycle on the registered inputs by now.
                    CALCULAR: begin
                        regResultado <= bus.resultadoALU;
                        regBanderas  <= bus.banderasALU;
                        regValido    <= 1'b1;
                        estadoActual <= MOSTRAR;
                    end
                    MOSTRAR: begin
                        if (bus.aceptado) begin
                            regValido    <= 1'b0;
                            regContador  <= regContador + 8'd1;
                            estadoActual <= CARGA_A;
                        end
                    end
                    default: begin
                        estadoActual <= CARGA_A;
                    end
                endcase
            end
        end
    end

    assign bus.operandoA           = regA;
    assign bus.operandoB           = regB;
    assign bus.seleccion           = regSeleccion;
    assign bus.resultado           = regResultado;
    assign bus.banderas            = regBanderas;
    assign bus.valido              = regValido;
    assign bus.error               = regError;
    assign bus.estado              = estadoActual;
    assign bus.contadorOperaciones = regContador;

endmodule

// File: tb/tb_secuenciador_alu.sv
// Scoreboard bench for secuenciador_alu: directed presses drive a stub ALU, expected
// results are queued on issue and checked by a monitor whenever valido rises.
module tb_secuenciador_alu;

    localparam int ancho = 3;

    typedef struct packed {
        logic [ancho:0] a;
        logic [ancho:0] b;
        logic [3:0]     sel;
        logic [ancho:0] res;
        logic [3:0]     flags;
    } esperado_t;

    logic reloj = 1'b0;
    logic reinicio;
    int   vectores = 0;
    int   fallos   = 0;

    esperado_t      cola[$];
    esperado_t      entrada;
    logic           validoPrevio = 1'b0;
    logic [ancho:0] lastA = '0;
    logic [ancho:0] lastB = '0;
    logic [3:0]     lastSel = '0;
    logic [7:0]     expCont = '0;
    logic [ancho:0] aluA, aluB, aluRes;

    secuenciador_alu_if #(.ancho(ancho)) bus ();

    secuenciador_alu #(.ancho(ancho)) dut (
        .reloj    (reloj),
        .reinicio (reinicio),
        .bus      (bus)
    );

    always #5 reloj = ~reloj;

    // Stub ALU for a 4-bit datapath: flags are {zero, msb, 0, 0}.
    always_comb begin
        aluA   = bus.operandoA;
        aluB   = bus.operandoB;
        aluRes = '0;
        case (bus.seleccion)
            4'd0: aluRes = aluA + aluB;
            4'd1: aluRes = aluA - aluB;
            4'd2: aluRes = aluA * aluB;
            4'd3: aluRes = (aluB == '0) ? '0 : aluA / aluB;
            4'd4: aluRes = (aluB == '0) ? '0 : aluA % aluB;
            4'd5: aluRes = aluA & aluB;
            4'd6: aluRes = aluA | aluB;
            4'd7: aluRes = aluA ^ aluB;
            4'd8: aluRes = aluA << aluB;
            4'd9: aluRes = aluA >> aluB;
            default: aluRes = '0;
        endcase
        bus.resultadoALU = aluRes;
        bus.banderasALU  = {(aluRes == '0), aluRes[ancho], 2'b00};
    end

    task automatic checkOutput(input string nombre, input logic [31:0] actual,
                               input logic [31:0] requerido);
        vectores++;
        if (actual !== requerido) begin
            fallos++;
            $display("[TB] FAIL %s: obtenido %0h, esperado %0h (t=%0t)",
                     nombre, actual, requerido, $time);
        end
    endtask

    // Monitor: every fresh result must match the oldest queued expectation.
    always @(negedge reloj) begin
        if (bus.valido && !validoPrevio) begin
            if (cola.size() == 0) begin
                vectores++;
                fallos++;
                $display("[TB] FAIL resultadoInesperado: obtenido %0h, esperado ninguno",
                         bus.resultado);
            end else begin
                entrada = cola.pop_front();
                checkOutput("resultado", 32'(bus.resultado), 32'(entrada.res));
                checkOutput("banderas", 32'(bus.banderas), 32'(entrada.flags));
                checkOutput("operandoA", 32'(bus.operandoA), 32'(entrada.a));
                checkOutput("operandoB", 32'(bus.operandoB), 32'(entrada.b));
                checkOutput("seleccionRes", 32'(bus.seleccion), 32'(entrada.sel));
            end
        end
        validoPrevio <= bus.valido;
    end

    task automatic pulsar(input logic [3:0] dato);
        @(negedge reloj);
        bus.entradaDatos     = dato;
        bus.entradaSeleccion = dato;
        bus.cargar           = 1'b1;
        @(negedge reloj);
        bus.cargar = 1'b0;
    endtask

    task automatic loadAB(input logic [3:0] a, input logic [3:0] b);
        pulsar(a);
        lastA = a;
        checkOutput("capturaA", 32'(bus.operandoA), 32'(a));
        checkOutput("estadoB", 32'(bus.estado), 32'd1);
        pulsar(b);
        lastB = b;
        checkOutput("capturaB", 32'(bus.operandoB), 32'(b));
        checkOutput("estadoOp", 32'(bus.estado), 32'd2);
    endtask

    // modo: 0 accept, 1 cancel in MOSTRAR, 2 accept held two cycles, 3 press ignored then accept
    task automatic finishOp(input logic [3:0] op, input logic [3:0] res,
                            input logic [3:0] flags, input int modo);
        cola.push_back('{a: lastA, b: lastB, sel: op, res: res, flags: flags});
        pulsar(op);
        lastSel = op;
        checkOutput("estadoCalcular", 32'(bus.estado), 32'd3);
        checkOutput("validoAntes", 32'(bus.valido), 32'd0);
        checkOutput("seleccion", 32'(bus.seleccion), 32'(op));
        @(negedge reloj);
        checkOutput("validoAlto", 32'(bus.valido), 32'd1);
        checkOutput("estadoMostrar", 32'(bus.estado), 32'd4);
        if (modo == 3) begin
            pulsar(4'hA);
            checkOutput("mostrarIgnoraPulso", 32'(bus.estado), 32'd4);
            checkOutput("resultadoRetenido", 32'(bus.resultado), 32'(res));
            checkOutput("operandoARetenido", 32'(bus.operandoA), 32'(lastA));
        end
        if (modo == 1) bus.cancelar = 1'b1;
        else bus.aceptado = 1'b1;
        @(negedge reloj);
        if (modo == 2) @(negedge reloj);
        bus.aceptado = 1'b0;
        bus.cancelar = 1'b0;
        if (modo != 1) expCont = expCont + 8'd1;
        checkOutput("validoBajo", 32'(bus.valido), 32'd0);
        checkOutput("estadoFinal", 32'(bus.estado), 32'd0);
        checkOutput("contador", 32'(bus.contadorOperaciones), 32'(expCont));
        checkOutput("resultadoTrasFin", 32'(bus.resultado), 32'(res));
    endtask

    task automatic applyStimulus();
        int n;
        // Reset with the button held: no edge until release and re-press.
        reinicio             = 1'b1;
        bus.cargar           = 1'b1;
        bus.cancelar         = 1'b0;
        bus.aceptado         = 1'b0;
        bus.entradaDatos     = 4'd7;
        bus.entradaSeleccion = 4'd7;
        repeat (3) @(negedge reloj);
        reinicio = 1'b0;
        repeat (3) @(negedge reloj);
        checkOutput("resetEstado", 32'(bus.estado), 32'd0);
        checkOutput("resetValido", 32'(bus.valido), 32'd0);
        checkOutput("resetError", 32'(bus.error), 32'd0);
        checkOutput("resetContador", 32'(bus.contadorOperaciones), 32'd0);
        checkOutput("resetOperandoA", 32'(bus.operandoA), 32'd0);
        checkOutput("resetResultado", 32'(bus.resultado), 32'd0);
        bus.cargar = 1'b0;

        loadAB(4'd5, 4'd3);
        finishOp(4'd0, 4'd8, 4'b0100, 0);
        loadAB(4'd5, 4'd3);  finishOp(4'd1, 4'd2,  4'b0000, 3);
        loadAB(4'd3, 4'd3);  finishOp(4'd2, 4'd9,  4'b0100, 0);
        loadAB(4'd7, 4'd2);  finishOp(4'd3, 4'd3,  4'b0000, 0);
        loadAB(4'd7, 4'd3);  finishOp(4'd4, 4'd1,  4'b0000, 0);
        loadAB(4'd12, 4'd10); finishOp(4'd5, 4'd8, 4'b0100, 0);
        loadAB(4'd12, 4'd3); finishOp(4'd6, 4'd15, 4'b0100, 0);
        loadAB(4'd12, 4'd2); finishOp(4'd9, 4'd3,  4'b0000, 2);

        // Invalid opcode: one-cycle error, selection untouched, then a valid retry.
        loadAB(4'd9, 4'd9);
        pulsar(4'd12);
        checkOutput("errorPulso", 32'(bus.error), 32'd1);
        checkOutput("errorEstado", 32'(bus.estado), 32'd2);
        checkOutput("errorSeleccion", 32'(bus.seleccion), 32'(lastSel));
        @(negedge reloj);
        checkOutput("errorUnCiclo", 32'(bus.error), 32'd0);
        finishOp(4'd7, 4'd0, 4'b1000, 0);

        // Cancel together with a press in CARGA_B.
        pulsar(4'd6);
        lastA = 4'd6;
        @(negedge reloj);
        bus.entradaDatos = 4'd1;
        bus.cargar       = 1'b1;
        bus.cancelar     = 1'b1;
        @(negedge reloj);
        bus.cargar   = 1'b0;
        bus.cancelar = 1'b0;
        checkOutput("cancelarEstado", 32'(bus.estado), 32'd0);
        checkOutput("cancelarOperandoB", 32'(bus.operandoB), 32'(lastB));
        checkOutput("cancelarOperandoA", 32'(bus.operandoA), 32'd6);

        loadAB(4'd5, 4'd3);
        finishOp(4'd1, 4'd2, 4'b0000, 1);

        n = 256 - int'(expCont);
        for (int i = 0; i < n; i++) begin
            loadAB(4'd2, 4'd2);
            finishOp(4'd0, 4'd4, 4'b0000, 0);
        end
        checkOutput("contadorVuelta", 32'(bus.contadorOperaciones), 32'd0);

        loadAB(4'd3, 4'd2);
        finishOp(4'd8, 4'd12, 4'b0100, 0);

        // Reset while in CALCULAR: the pending result must never appear.
        loadAB(4'd4, 4'd4);
        pulsar(4'd0);
        checkOutput("estadoAntesReset", 32'(bus.estado), 32'd3);
        reinicio = 1'b1;
        @(negedge reloj);
        reinicio = 1'b0;
        checkOutput("rstCalcEstado", 32'(bus.estado), 32'd0);
        checkOutput("rstCalcValido", 32'(bus.valido), 32'd0);
        checkOutput("rstCalcContador", 32'(bus.contadorOperaciones), 32'd0);
        checkOutput("rstCalcOperandos", 32'({bus.operandoA, bus.operandoB}), 32'd0);
        checkOutput("rstCalcSeleccion", 32'(bus.seleccion), 32'd0);
        checkOutput("rstCalcResultado", 32'({bus.resultado, bus.banderas}), 32'd0);
        @(negedge reloj);
        checkOutput("rstCalcSigueBajo", 32'(bus.valido), 32'd0);
    endtask

    initial begin
        applyStimulus();
        repeat (2) @(negedge reloj);
        checkOutput("colaPendiente", 32'(cola.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: obtenido timeout, esperado fin");
        $fatal(1, "[TB] watchdog");
    end

endmodule
